// File: rtl/decode_stage.sv
// Decode stage of the multi-cycle MIPS core: accepts an instruction from fetch, reads the
// register file, and hands an operand/control bundle to execute.
module decode_stage #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    output logic        rf_en,
    output logic [4:0]  rf_read_reg1,
    output logic [4:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        rf_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] imm_ext,
    output logic [4:0]  dest_reg,
    output logic [5:0]  funct,
    output logic [4:0]  shamt,
    output logic [7:0]  ctrl,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic        illegal,
    output logic        rf_timeout
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] cnt_next;
    logic [4:0]    rs_q, rs_d;
    logic [4:0]    rt_q, rt_d;
    logic [4:0]    shamt_q, shamt_d;
    logic [5:0]    funct_q, funct_d;
    logic [4:0]    dest_q, dest_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [31:0]   imm_q, imm_d;
    logic [31:0]   pc4_q, pc4_d;
    logic [31:0]   bt_q, bt_d;
    logic [31:0]   jt_q, jt_d;

    // Decode of the incoming word; only registered on accept.
    logic [7:0]  dec_ctrl;
    logic [4:0]  dec_dest;
    logic        dec_illegal;
    logic [31:0] dec_imm;
    logic [31:0] dec_pc4;

    always_comb begin
        dec_ctrl    = 8'b0;
        dec_dest    = 5'd0;
        dec_illegal = 1'b0;
        case (instr[31:26])
            6'h00: begin
                dec_ctrl = 8'b1000_0010;
                dec_dest = instr[15:11];
            end
            6'h08: begin
                dec_ctrl = 8'b1001_0000;
                dec_dest = instr[20:16];
            end
            6'h23: begin
                dec_ctrl = 8'b1101_0000;
                dec_dest = instr[20:16];
            end
            6'h2B:   dec_ctrl = 8'b0011_0000;
            6'h04:   dec_ctrl = 8'b0000_1001;
            6'h02:   dec_ctrl = 8'b0000_0100;
            default: dec_illegal = 1'b1;
        endcase
        // Writes to $0 are architectural no-ops, so drop reg_write.
        if (dec_dest == 5'd0) begin
            dec_ctrl[7] = 1'b0;
        end
        dec_imm = {{16{instr[15]}}, instr[15:0]};
        dec_pc4 = pc_in + 32'd4;
    end

    assign cnt_next = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        shamt_d   = shamt_q;
        funct_d   = funct_q;
        dest_d    = dest_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        bt_d      = bt_q;
        jt_d      = jt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d   = StReq;
                    rs_d      = instr[25:21];
                    rt_d      = instr[20:16];
                    shamt_d   = instr[10:6];
                    funct_d   = instr[5:0];
                    dest_d    = dec_dest;
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    imm_d     = dec_imm;
                    pc4_d     = dec_pc4;
                    bt_d      = dec_pc4 + {dec_imm[29:0], 2'b00};
                    jt_d      = {dec_pc4[31:28], instr[25:0], 2'b00};
                end
            end
            StReq: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                cnt_d = cnt_next;
                if (rf_done) begin
                    state_d   = StOut;
                    op_a_d    = rf_read_data1;
                    op_b_d    = rf_read_data2;
                    timeout_d = 1'b0;
                end else if (cnt_next == TW'(TIMEOUT)) begin
                    state_d   = StOut;
                    op_a_d    = 32'd0;
                    op_b_d    = 32'd0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            shamt_q   <= 5'd0;
            funct_q   <= 6'd0;
            dest_q    <= 5'd0;
            ctrl_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            imm_q     <= 32'd0;
            pc4_q     <= 32'd0;
            bt_q      <= 32'd0;
            jt_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            shamt_q   <= shamt_d;
            funct_q   <= funct_d;
            dest_q    <= dest_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            bt_q      <= bt_d;
            jt_q      <= jt_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign in_ready      = (state_q == StIdle);
    assign rf_en         = (state_q == StReq);
    assign out_valid     = (state_q == StOut);
    assign rf_read_reg1  = rs_q;
    assign rf_read_reg2  = rt_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign imm_ext       = imm_q;
    assign dest_reg      = dest_q;
    assign funct         = funct_q;
    assign shamt         = shamt_q;
    assign ctrl          = ctrl_q;
    assign pc_plus4      = pc4_q;
    assign branch_target = bt_q;
    assign jump_target   = jt_q;
    assign illegal       = illegal_q;
    assign rf_timeout    = timeout_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, a register-file responder and a
// monitor that compares each presented bundle against the queued expectation.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        rf_en;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        rf_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm_ext;
    logic [4:0]  dest_reg;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [7:0]  ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        illegal;
    logic        rf_timeout;

    decode_stage #(.TIMEOUT(15), .TW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_in(pc_in), .rf_en(rf_en), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2), .rf_done(rf_done),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .imm_ext(imm_ext), .dest_reg(dest_reg), .funct(funct), .shamt(shamt), .ctrl(ctrl),
        .pc_plus4(pc_plus4), .branch_target(branch_target), .jump_target(jump_target),
        .illegal(illegal), .rf_timeout(rf_timeout)
    );

    typedef struct {
        logic [31:0] instr, pc, d1, d2;
        int          delay, hold, lat;
        logic [31:0] op_a, op_b, imm, pc4, bt, jt;
        logic [4:0]  dest, shamt;
        logic [5:0]  funct;
        logic [7:0]  ctrl;
        logic        ill, to;
    } vec_t;

    vec_t        vecs[$];
    vec_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rf_en_cycles = 0;
    int          rf_delay = -1;
    logic [31:0] rf_d1 = 32'd0;
    logic [31:0] rf_d2 = 32'd0;
    logic [4:0]  exp_r1 = 5'd0;
    logic [4:0]  exp_r2 = 5'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(
        input logic [31:0] i_instr, input logic [31:0] i_pc, input logic [31:0] i_d1,
        input logic [31:0] i_d2, input int i_delay, input int i_hold, input int i_lat,
        input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_imm,
        input logic [4:0] e_dest, input logic [5:0] e_funct, input logic [4:0] e_shamt,
        input logic [7:0] e_ctrl, input logic [31:0] e_pc4, input logic [31:0] e_bt,
        input logic [31:0] e_jt, input logic e_ill, input logic e_to);
        vec_t v;
        v.instr = i_instr; v.pc = i_pc; v.d1 = i_d1; v.d2 = i_d2;
        v.delay = i_delay; v.hold = i_hold; v.lat = i_lat;
        v.op_a = e_a; v.op_b = e_b; v.imm = e_imm; v.dest = e_dest; v.funct = e_funct;
        v.shamt = e_shamt; v.ctrl = e_ctrl; v.pc4 = e_pc4; v.bt = e_bt; v.jt = e_jt;
        v.ill = e_ill; v.to = e_to;
        vecs.push_back(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".rf_en"}, 32'(rf_en), 32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rf_read_reg1"}, 32'(rf_read_reg1), 32'd0);
        check({tag, ".rf_read_reg2"}, 32'(rf_read_reg2), 32'd0);
        check({tag, ".op_a"}, op_a, 32'd0);
        check({tag, ".op_b"}, op_b, 32'd0);
        check({tag, ".imm_ext"}, imm_ext, 32'd0);
        check({tag, ".dest_reg"}, 32'(dest_reg), 32'd0);
        check({tag, ".funct"}, 32'(funct), 32'd0);
        check({tag, ".shamt"}, 32'(shamt), 32'd0);
        check({tag, ".ctrl"}, 32'(ctrl), 32'd0);
        check({tag, ".pc_plus4"}, pc_plus4, 32'd0);
        check({tag, ".branch_target"}, branch_target, 32'd0);
        check({tag, ".jump_target"}, jump_target, 32'd0);
        check({tag, ".illegal"}, 32'(illegal), 32'd0);
        check({tag, ".rf_timeout"}, 32'(rf_timeout), 32'd0);
    endtask

    // Register-file model: answers a request after rf_delay WAIT cycles; negative never answers.
    initial begin
        rf_done = 1'b0;
        rf_read_data1 = 32'hDEAD_BEEF;
        rf_read_data2 = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (rf_en === 1'b1 && rf_delay >= 0) begin
                @(posedge clk); #1;
                repeat (rf_delay) begin
                    @(posedge clk); #1;
                end
                rf_done = 1'b1;
                rf_read_data1 = rf_d1;
                rf_read_data2 = rf_d2;
                @(posedge clk); #1;
                rf_done = 1'b0;
                rf_read_data1 = 32'hDEAD_BEEF;
                rf_read_data2 = 32'hDEAD_BEEF;
            end
        end
    end

    always @(negedge clk) begin
        if (rf_en === 1'b1) begin
            rf_en_cycles++;
            check("rf_read_reg1", 32'(rf_read_reg1), 32'(exp_r1));
            check("rf_read_reg2", 32'(rf_read_reg2), 32'(exp_r2));
        end
    end

    // Monitor: every cycle the bundle is offered it must match the head of the queue.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1, expected no bundle");
                end else begin
                    e = exp_q[0];
                    check("op_a", op_a, e.op_a);
                    check("op_b", op_b, e.op_b);
                    check("imm_ext", imm_ext, e.imm);
                    check("dest_reg", 32'(dest_reg), 32'(e.dest));
                    check("funct", 32'(funct), 32'(e.funct));
                    check("shamt", 32'(shamt), 32'(e.shamt));
                    check("ctrl", 32'(ctrl), 32'(e.ctrl));
                    check("pc_plus4", pc_plus4, e.pc4);
                    check("branch_target", branch_target, e.bt);
                    check("jump_target", jump_target, e.jt);
                    check("illegal", 32'(illegal), 32'(e.ill));
                    check("rf_timeout", 32'(rf_timeout), 32'(e.to));
                    if (out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        int   w;
        int   lat;
        int   en0;
        v = vecs[idx];
        exp_q.push_back(v);
        exp_r1   = v.instr[25:21];
        exp_r2   = v.instr[20:16];
        rf_delay = v.delay;
        rf_d1    = v.d1;
        rf_d2    = v.d2;
        en0      = rf_en_cycles;
        instr    = v.instr;
        pc_in    = v.pc;
        in_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (w == 1) check("out_valid_dropped", 32'(out_valid), 32'd0);
        end while (in_ready !== 1'b1 && w < 20);
        check("accept_wait", 32'(w), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 60);
        check("latency", 32'(lat), 32'(v.lat));
        if (v.hold > 0 && idx + 1 < vecs.size()) begin
            instr    = vecs[idx + 1].instr;
            pc_in    = vecs[idx + 1].pc;
            in_valid = 1'b1;
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rf_en_cycles", 32'(rf_en_cycles - en0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        pc_in     = 32'd0;

        // instr, pc, d1, d2, delay, hold, lat, op_a, op_b, imm, dest, funct, shamt, ctrl,
        // pc+4, branch target, jump target, illegal, timeout
        add_vec(32'h012A4020, 32'h100, 32'd5, 32'd7, 0, 0, 3, 32'd5, 32'd7, 32'h4020, 5'd8,
                6'h20, 5'd0, 8'h82, 32'h104, 32'h10184, 32'h04A90080, 1'b0, 1'b0);
        add_vec(32'h1109FFFE, 32'h200, 32'h11, 32'h22, 2, 5, 5, 32'h11, 32'h22, 32'hFFFFFFFE,
                5'd0, 6'h3E, 5'h1F, 8'h09, 32'h204, 32'h1FC, 32'h0427FFF8, 1'b0, 1'b0);
        add_vec(32'h8D2A0010, 32'h1000, 32'h33, 32'h44, -1, 0, 17, 32'd0, 32'd0, 32'h10,
                5'd10, 6'h10, 5'd0, 8'hD0, 32'h1004, 32'h1044, 32'h04A80040, 1'b0, 1'b1);
        add_vec(32'hFC000000, 32'h300, 32'd3, 32'd4, 1, 0, 4, 32'd3, 32'd4, 32'd0, 5'd0,
                6'h00, 5'd0, 8'h00, 32'h304, 32'h304, 32'h0, 1'b1, 1'b0);
        add_vec(32'h20000005, 32'h400, 32'd1, 32'd2, 0, 0, 3, 32'd1, 32'd2, 32'd5, 5'd0,
                6'h05, 5'd0, 8'h10, 32'h404, 32'h418, 32'h14, 1'b0, 1'b0);
        add_vec(32'hAD2A0008, 32'hFFFFFFFC, 32'd9, 32'd10, 0, 0, 3, 32'd9, 32'd10, 32'd8, 5'd0,
                6'h08, 5'd0, 8'h30, 32'h0, 32'h20, 32'h04A80020, 1'b0, 1'b0);
        add_vec(32'h08000040, 32'hF0000000, 32'hAAAA, 32'hBBBB, 3, 0, 6, 32'hAAAA, 32'hBBBB,
                32'h40, 5'd0, 6'h00, 5'd1, 8'h04, 32'hF0000004, 32'hF0000104, 32'hF0000100,
                1'b0, 1'b0);
        add_vec(32'h012A0020, 32'h500, 32'h55, 32'h66, 1, 0, 4, 32'h55, 32'h66, 32'h20, 5'd0,
                6'h20, 5'd0, 8'h02, 32'h504, 32'h584, 32'h04A80080, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_vec(0);

        // Reset while waiting on the register file.
        rf_delay = -1;
        exp_r1   = 5'd9;
        exp_r2   = 5'd10;
        instr    = 32'h012A4020;
        pc_in    = 32'h100;
        in_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (in_ready !== 1'b1 && w < 20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("midwait_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 1; i < vecs.size(); i++) begin
            run_vec(i);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage between fetch and execute in the multi-cycle MIPS core.
- Accepts one instruction and PC from fetch over a valid/ready handshake, decodes fields and control, and issues a read request to the register file.
- Waits for the register-file done strobe, captures both operands, and presents an operand/control bundle to execute over a second valid/ready handshake.
- Computes the sign-extended immediate, PC+4, branch target and jump target.

Parameters:
- TIMEOUT, 15: max cycles spent in WAIT for rf_done before an error abort.
- TW, 4: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  decode can accept an instruction.
- instr  in  32  instruction word.
- pc_in  in  32  PC of instr.
- rf_en  out  1  register-file read request.
- rf_read_reg1  out  5  rs field.
- rf_read_reg2  out  5  rt field.
- rf_read_data1  in  32  rs operand.
- rf_read_data2  in  32  rt operand.
- rf_done  in  1  register-file read complete.
- out_valid  out  1  bundle valid to execute.
- out_ready  in  1  execute accepts the bundle.
- op_a  out  32  captured rs value.
- op_b  out  32  captured rt value.
- imm_ext  out  32  sign-extended imm16.
- dest_reg  out  5  rd for R-type; rt otherwise; 0 if no write.
- funct  out  6  instr[5:0].
- shamt  out  5  instr[10:6].
- ctrl  out  8  {reg_write, mem_read, mem_write, alu_src, branch, jump, alu_op[1:0]}.
- pc_plus4  out  32  pc_in+4.
- branch_target  out  32  pc_in + 4 + (imm_ext<<2), modulo 2^32.
- jump_target  out  32  {pc_plus4[31:28], instr[25:0], 2'b00}.
- illegal  out  1  opcode not in the supported set (valid with out_valid).
- rf_timeout  out  1  WAIT aborted by timeout (valid with out_valid).

Behaviour:
- Reset, asynchronous: state=IDLE; every output 0 except in_ready=1; counter=0.
- FSM states IDLE, REQ, WAIT, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, latch instr/pc_in and decode -> REQ. in_ready is 0 in every other state.
- REQ: rf_en=1 for exactly one cycle with rf_read_reg1=instr[25:21] and rf_read_reg2=instr[20:16] -> WAIT. Read-reg outputs hold their value through WAIT.
- WAIT: rf_en=0; counter increments each cycle.
  - rf_done sampled 1: capture op_a/op_b from rf_read_data1/2, rf_timeout=0 -> OUT.
  - Counter reaches TIMEOUT without rf_done: op_a=op_b=0, rf_timeout=1 -> OUT.
  - rf_done is ignored in every other state.
- OUT: out_valid=1; the bundle is stable until out_ready.
  - On out_valid&out_ready -> IDLE, out_valid drops the next cycle.
  - Minimum latency from accept to out_valid: 3 cycles (REQ, WAIT with rf_done already 1, OUT).
  - Throughput: at most one instruction per 4 cycles. No accept in the same cycle as the OUT handshake.
- Decode, registered at accept, by opcode=instr[31:26]:
  - 0x00 R-type: reg_write=1, alu_op=10, dest=rd.
  - 0x08 addi: reg_write=1, alu_src=1, alu_op=00, dest=rt.
  - 0x23 lw: reg_write=1, mem_read=1, alu_src=1, alu_op=00, dest=rt.
  - 0x2B sw: mem_write=1, alu_src=1, alu_op=00, dest=0.
  - 0x04 beq: branch=1, alu_op=01, dest=0.
  - 0x02 j: jump=1, dest=0.
  - Any other opcode: ctrl=0, dest=0, illegal=1. The FSM still runs the full sequence.
- A destination of register 0 forces reg_write=0.
- imm_ext = {{16{instr[15]}}, instr[15:0]}.
- All arithmetic is 32-bit and wraps; the carry out is dropped.
- rst asserted mid-operation: immediate return to IDLE with the reset values above. A pending rf read is abandoned and rf_en drops asynchronously.

Test Plan:
- Reset: assert rst mid-WAIT -> next cycle in_ready=1, rf_en=0, out_valid=0, all outputs 0.
- R-type add: instr=0x012A4020 (add $8,$9,$10), pc_in=0x100, regfile returns 5/7, rf_done 1 cycle after REQ -> op_a=5, op_b=7, dest_reg=8, ctrl=8'b1000_0010, pc_plus4=0x104, out_valid 3 cycles after accept.
- beq with negative offset: instr=0x1109FFFE, pc_in=0x200 -> imm_ext=0xFFFFFFFE, branch_target=0x1FC, ctrl=8'b0000_1001, dest_reg=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready stays 0 and the bundle is unchanged. Release -> accept in IDLE the following cycle.
- Timeout: never assert rf_done, TIMEOUT=15 -> out_valid with rf_timeout=1, op_a=op_b=0. rf_en was high only during the REQ cycle.
- Illegal/zero dest: opcode 0x3F -> illegal=1, ctrl=0. addi $0 (0x20000005) -> reg_write=0, dest_reg=0, imm_ext=5.
